// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if
// Bundles the three buses the framebuffer arbiter sits between:
//   - scanout prefetch: vga_req, vga_urgent, vga_addr in; vga_grant,
//     vga_valid, vga_data out
//   - cpu device bus: cpu_req, cpu_we, cpu_addr, cpu_wdata in; cpu_ack,
//     cpu_rdata out
//   - single-port RAM: mem_en, mem_we, mem_addr, mem_wdata out; mem_rdata in
// slave modport is the arbiter's view; master is the view of whatever
// drives the requests and hosts the RAM.
interface vga_fb_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  vga_req;
  logic                  vga_urgent;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic                  vga_grant;
  logic                  vga_valid;
  logic [DATA_WIDTH-1:0] vga_data;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_urgent, vga_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata,
    output vga_grant, vga_valid, vga_data,
    output cpu_ack, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_req, vga_urgent, vga_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata,
    input  vga_grant, vga_valid, vga_data,
    input  cpu_ack, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between VGA scanout
// prefetch and CPU loads/stores. Scanout normally wins, a bounded wait
// counter forces a CPU slot after CPU_MAX_WAIT VGA grants, and an urgent
// scanout request beats everything. Grant to response is 3 cycles, one
// access per cycle.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low
//   bus   - vga_fb_arbiter_if.slave (scanout, cpu and RAM signals)
module vga_fb_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_fb_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_VGA  = 2'd1,
    OWNER_CPU  = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  owner_e                grantOwner;
  logic                  cpuAvail;
  logic                  cpuForce;

  logic [3:0]            waitCnt_q, waitCnt_d;
  logic                  cpuBusy_q, cpuBusy_d;

  owner_e                tag1_q, tag2_q;
  logic                  cpuWrite2_q;

  logic                  memEn_q, memWe_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;

  logic                  vgaValid_q, cpuAck_q;
  logic [DATA_WIDTH-1:0] vgaData_q, cpuRdata_q;

  // cpu_req stays high until its ack, so busy masks it while in flight.
  assign cpuAvail = bus.cpu_req & ~cpuBusy_q;
  assign cpuForce = cpuAvail & (waitCnt_q == MAX_WAIT);

  always_comb begin
    grantOwner = OWNER_NONE;
    if (reset) begin
      if (bus.vga_urgent && bus.vga_req) grantOwner = OWNER_VGA;
      else if (cpuForce)                 grantOwner = OWNER_CPU;
      else if (bus.vga_req)              grantOwner = OWNER_VGA;
      else if (cpuAvail)                 grantOwner = OWNER_CPU;
    end
  end

  always_comb begin
    waitCnt_d = waitCnt_q;
    cpuBusy_d = cpuBusy_q;
    if (grantOwner == OWNER_CPU || !bus.cpu_req) begin
      waitCnt_d = 4'd0;
    end else if (grantOwner == OWNER_VGA && cpuAvail && waitCnt_q != MAX_WAIT) begin
      waitCnt_d = waitCnt_q + 4'd1;
    end
    // Busy is still set during the ack cycle so the held request cannot be
    // granted a second time before the master has dropped it.
    if (cpuAck_q)                  cpuBusy_d = 1'b0;
    if (grantOwner == OWNER_CPU)   cpuBusy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      waitCnt_q   <= 4'd0;
      cpuBusy_q   <= 1'b0;
      tag1_q      <= OWNER_NONE;
      tag2_q      <= OWNER_NONE;
      cpuWrite2_q <= 1'b0;
      memEn_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      vgaValid_q  <= 1'b0;
      vgaData_q   <= '0;
      cpuAck_q    <= 1'b0;
      cpuRdata_q  <= '0;
    end else begin
      waitCnt_q   <= waitCnt_d;
      cpuBusy_q   <= cpuBusy_d;

      memEn_q     <= (grantOwner != OWNER_NONE);
      memWe_q     <= (grantOwner == OWNER_CPU) && bus.cpu_we;
      if (grantOwner == OWNER_VGA)      memAddr_q <= bus.vga_addr;
      else if (grantOwner == OWNER_CPU) memAddr_q <= bus.cpu_addr;
      if (grantOwner == OWNER_CPU)      memWdata_q <= bus.cpu_wdata;

      // Owner tags follow each access so mem_rdata is steered correctly.
      tag1_q      <= grantOwner;
      tag2_q      <= tag1_q;
      cpuWrite2_q <= memWe_q;

      vgaValid_q  <= (tag2_q == OWNER_VGA);
      if (tag2_q == OWNER_VGA) vgaData_q <= bus.mem_rdata;
      cpuAck_q    <= (tag2_q == OWNER_CPU);
      if (tag2_q == OWNER_CPU && !cpuWrite2_q) cpuRdata_q <= bus.mem_rdata;
    end
  end

  assign bus.vga_grant = (grantOwner == OWNER_VGA);
  assign bus.vga_valid = vgaValid_q;
  assign bus.vga_data  = vgaData_q;
  assign bus.cpu_ack   = cpuAck_q;
  assign bus.cpu_rdata = cpuRdata_q;
  assign bus.mem_en    = memEn_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// Directed scenarios followed by a randomized phase. A transaction-level
// model (priority rules, wait count, a queue of in-flight accesses and a
// shadow copy of the framebuffer) predicts every output each cycle.
module tb_vga_fb_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset;

  vga_fb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vga_fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM: one-cycle read latency, write on enable.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    int            cyc;
    bit            isCpu;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } access_t;

  access_t       inflight[$];
  logic [DW-1:0] shadow [0:65535];
  int            mWait;
  bit            mBusy;
  logic [DW-1:0] expCpuRdata, expVgaData;
  bit            justReset;

  int cyc, curCyc;
  int vectors, miscompares;

  bit            stReset, stVgaReq, stVgaUrg, vgaStream;
  logic [AW-1:0] stVgaAddr;
  bit            cpuPending, stCpuWe;
  logic [AW-1:0] stCpuAddr;
  logic [DW-1:0] stCpuWdata;

  int            lastGrant;
  bit            obsGrant, obsValid, obsAck, obsMemEn;
  logic [DW-1:0] obsRdata;

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, curCyc);
    end
  endtask

  task automatic applyStimulus();
    reset          = stReset;
    bus.vga_req    = stVgaReq;
    bus.vga_urgent = stVgaUrg;
    bus.vga_addr   = stVgaAddr;
    bus.cpu_req    = cpuPending;
    bus.cpu_we     = stCpuWe;
    bus.cpu_addr   = stCpuAddr;
    bus.cpu_wdata  = stCpuWdata;
  endtask

  // 0 = idle, 1 = scanout, 2 = cpu, straight from the priority list.
  function automatic int modelGrant();
    bit avail;
    avail = cpuPending && !mBusy;
    if (!stReset)                 return 0;
    if (stVgaUrg && stVgaReq)     return 1;
    if (avail && mWait == MAXW)   return 2;
    if (stVgaReq)                 return 1;
    if (avail)                    return 2;
    return 0;
  endfunction

  task automatic runCycle();
    int      g;
    bit      memHit, respHit, avail, expValid, expAck;
    access_t memRec, respRec, rec;
    @(negedge clk);
    applyStimulus();
    #1;
    curCyc  = cyc;
    g       = modelGrant();
    avail   = cpuPending && !mBusy;
    memHit  = 1'b0;
    respHit = 1'b0;
    foreach (inflight[i]) begin
      if (inflight[i].cyc == cyc - 1) begin memHit  = 1'b1; memRec  = inflight[i]; end
      if (inflight[i].cyc == cyc - 3) begin respHit = 1'b1; respRec = inflight[i]; end
    end
    expValid = respHit && !respRec.isCpu;
    expAck   = respHit && respRec.isCpu;
    if (expValid) expVgaData = respRec.rdata;
    if (expAck && !respRec.we) expCpuRdata = respRec.rdata;

    checkOutput("vga_grant", bus.vga_grant, g == 1);
    checkOutput("mem_en", bus.mem_en, memHit);
    if (memHit) begin
      checkOutput("mem_we", bus.mem_we, memRec.isCpu && memRec.we);
      checkOutput("mem_addr", bus.mem_addr, memRec.addr);
      if (memRec.isCpu && memRec.we) checkOutput("mem_wdata", bus.mem_wdata, memRec.wdata);
    end else begin
      checkOutput("mem_we_idle", bus.mem_we, 1'b0);
    end
    checkOutput("vga_valid", bus.vga_valid, expValid);
    checkOutput("vga_data", bus.vga_data, expVgaData);
    checkOutput("cpu_ack", bus.cpu_ack, expAck);
    checkOutput("cpu_rdata", bus.cpu_rdata, expCpuRdata);
    if (justReset) begin
      checkOutput("mem_addr_rst", bus.mem_addr, 16'h0000);
      checkOutput("mem_wdata_rst", bus.mem_wdata, 16'h0000);
    end

    obsGrant = bus.vga_grant;
    obsValid = bus.vga_valid;
    obsAck   = bus.cpu_ack;
    obsMemEn = bus.mem_en;
    obsRdata = bus.cpu_rdata;

    // Model state after the closing clock edge.
    justReset = 1'b0;
    if (!stReset) begin
      inflight.delete();
      mWait       = 0;
      mBusy       = 1'b0;
      expCpuRdata = '0;
      expVgaData  = '0;
      justReset   = 1'b1;
    end else begin
      if (expAck) mBusy = 1'b0;
      if (g == 2) begin
        rec.cyc = cyc; rec.isCpu = 1'b1; rec.we = stCpuWe;
        rec.addr = stCpuAddr; rec.wdata = stCpuWdata; rec.rdata = shadow[stCpuAddr];
        if (stCpuWe) shadow[stCpuAddr] = stCpuWdata;
        inflight.push_back(rec);
        mBusy = 1'b1;
        mWait = 0;
      end else if (g == 1) begin
        rec.cyc = cyc; rec.isCpu = 1'b0; rec.we = 1'b0;
        rec.addr = stVgaAddr; rec.wdata = '0; rec.rdata = shadow[stVgaAddr];
        inflight.push_back(rec);
        if (avail && mWait < MAXW) mWait++;
      end
      if (!cpuPending) mWait = 0;
    end
    while (inflight.size() > 0 && inflight[0].cyc < cyc - 2) void'(inflight.pop_front());

    // Bus masters react: cpu drops its request after the ack, scanout
    // advances on each grant.
    if (expAck) cpuPending = 1'b0;
    if (g == 1 && vgaStream) stVgaAddr = stVgaAddr + 16'd1;
    lastGrant = g;
    cyc++;
  endtask

  initial begin
    int start, ackCnt, ackRel, noGrantRel, validCnt, firstValid, lastValid, grants, memEnCnt;
    logic [DW-1:0] rdAtAck;

    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 16'(i * 40503 + 4951);
      shadow[i] = ram[i];
    end
    ram[16'h0040]    = 16'hBEEF;
    shadow[16'h0040] = 16'hBEEF;

    vectors = 0; miscompares = 0; cyc = 0; curCyc = 0;
    mWait = 0; mBusy = 1'b0; expCpuRdata = '0; expVgaData = '0; justReset = 1'b1;
    stReset = 1'b0; stVgaReq = 1'b0; stVgaUrg = 1'b0; vgaStream = 1'b1;
    stVgaAddr = '0; cpuPending = 1'b0; stCpuWe = 1'b0; stCpuAddr = '0; stCpuWdata = '0;
    applyStimulus();
    repeat (2) runCycle();
    stReset = 1'b1;

    $display("[TB] solo cpu read and write");
    stCpuWe = 1'b0; stCpuAddr = 16'h0040; cpuPending = 1'b1;
    start = cyc; ackCnt = 0; ackRel = -1; rdAtAck = '0;
    repeat (8) begin
      runCycle();
      if (obsAck) begin ackCnt++; if (ackRel < 0) ackRel = curCyc - start; rdAtAck = obsRdata; end
    end
    checkOutput("cpu_rd_latency", ackRel, 3);
    checkOutput("cpu_rd_ack_count", ackCnt, 1);
    checkOutput("cpu_rd_data", rdAtAck, 16'hBEEF);

    stCpuWe = 1'b1; stCpuAddr = 16'h0041; stCpuWdata = 16'h1234; cpuPending = 1'b1;
    start = cyc; ackCnt = 0; ackRel = -1;
    repeat (8) begin
      runCycle();
      if (obsAck) begin ackCnt++; if (ackRel < 0) ackRel = curCyc - start; end
    end
    checkOutput("cpu_wr_latency", ackRel, 3);
    checkOutput("cpu_wr_ack_count", ackCnt, 1);
    checkOutput("cpu_wr_ram", ram[16'h0041], 16'h1234);

    $display("[TB] streaming scanout");
    stVgaAddr = 16'h0100; vgaStream = 1'b1; stVgaReq = 1'b1;
    start = cyc; grants = 0; validCnt = 0; firstValid = -1; lastValid = -1;
    repeat (14) begin
      if (grants == 8) stVgaReq = 1'b0;
      runCycle();
      if (lastGrant == 1) grants++;
      if (obsValid) begin
        validCnt++;
        if (firstValid < 0) firstValid = curCyc - start;
        lastValid = curCyc - start;
      end
    end
    checkOutput("stream_valid_count", validCnt, 8);
    checkOutput("stream_first_valid", firstValid, 3);
    checkOutput("stream_back_to_back", lastValid - firstValid, 7);

    $display("[TB] starvation bound");
    stVgaAddr = 16'h0200; stVgaReq = 1'b1; cpuPending = 1'b1; stCpuWe = 1'b0; stCpuAddr = 16'h0080;
    start = cyc; noGrantRel = -1; ackRel = -1;
    repeat (10) begin
      runCycle();
      if (!obsGrant && noGrantRel < 0) noGrantRel = curCyc - start;
      if (obsAck && ackRel < 0) ackRel = curCyc - start;
    end
    checkOutput("starve_cpu_slot", noGrantRel, 4);
    checkOutput("starve_cpu_ack", ackRel, 7);
    stVgaReq = 1'b0;
    repeat (4) runCycle();

    $display("[TB] urgency override");
    stVgaReq = 1'b1; stVgaUrg = 1'b1; cpuPending = 1'b1; stCpuAddr = 16'h0081;
    start = cyc; noGrantRel = -1; ackRel = -1;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) stVgaUrg = 1'b0;
      runCycle();
      if (!obsGrant && noGrantRel < 0) noGrantRel = curCyc - start;
      if (obsAck && ackRel < 0) ackRel = curCyc - start;
    end
    checkOutput("urgent_cpu_slot", noGrantRel, 10);
    checkOutput("urgent_cpu_ack", ackRel, 13);
    stVgaReq = 1'b0;
    repeat (4) runCycle();

    $display("[TB] reset mid-flight");
    stVgaReq = 1'b1; stVgaAddr = 16'h0300; validCnt = 0;
    runCycle();
    if (obsValid) validCnt++;
    stVgaReq = 1'b0; stReset = 1'b0;
    runCycle();
    if (obsValid) validCnt++;
    stReset = 1'b1;
    repeat (4) begin runCycle(); if (obsValid) validCnt++; end
    checkOutput("reset_drop_valid", validCnt, 0);
    stCpuWe = 1'b0; stCpuAddr = 16'h0042; cpuPending = 1'b1;
    start = cyc; ackRel = -1;
    repeat (6) begin runCycle(); if (obsAck && ackRel < 0) ackRel = curCyc - start; end
    checkOutput("post_reset_latency", ackRel, 3);

    $display("[TB] idle then mixed");
    memEnCnt = 0;
    repeat (5) begin runCycle(); if (obsMemEn) memEnCnt++; end
    checkOutput("idle_mem_en", memEnCnt, 0);
    stVgaReq = 1'b1; stVgaAddr = 16'h0400; cpuPending = 1'b1; stCpuAddr = 16'h0043;
    start = cyc; firstValid = -1; ackRel = -1;
    runCycle();
    if (obsValid && firstValid < 0) firstValid = curCyc - start;
    stVgaReq = 1'b0;
    repeat (7) begin
      runCycle();
      if (obsValid && firstValid < 0) firstValid = curCyc - start;
      if (obsAck && ackRel < 0) ackRel = curCyc - start;
    end
    checkOutput("mixed_vga_resp", firstValid, 3);
    checkOutput("mixed_cpu_resp", ackRel, 4);

    $display("[TB] randomized traffic");
    vgaStream = 1'b0;
    repeat (400) begin
      stVgaReq  = 1'($urandom_range(0, 1));
      stVgaUrg  = ($urandom_range(0, 7) == 0);
      stVgaAddr = 16'($urandom_range(0, 63));
      if (!cpuPending && $urandom_range(0, 2) == 0) begin
        cpuPending = 1'b1;
        stCpuWe    = 1'($urandom_range(0, 1));
        stCpuAddr  = 16'($urandom_range(0, 63));
        stCpuWdata = 16'($urandom);
      end
      stReset = ($urandom_range(0, 99) != 0);
      runCycle();
    end
    stReset = 1'b1; stVgaReq = 1'b0; stVgaUrg = 1'b0;
    repeat (8) runCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
